div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 22 ++
 rtl/div_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Pipeline <-> divider signal bundle: start/operands/flush in, busy/writeback out.
interface div_unit_if;
  logic        HasDivE;
  logic        DivSignedE;
  logic [31:0] DivDividendE;
  logic [31:0] DivDivisorE;
  logic        DivCancel;
  logic        DivBusy;
  logic        HasDivW;
  logic [31:0] DivHiW;
  logic [31:0] DivLoW;

  modport master (
    output HasDivE, DivSignedE, DivDividendE, DivDivisorE, DivCancel,
    input  DivBusy, HasDivW, DivHiW, DivLoW
  );

  modport slave (
    input  HasDivE, DivSignedE, DivDividendE, DivDivisorE, DivCancel,
    output DivBusy, HasDivW, DivHiW, DivLoW
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU: one restoring shift-subtract step per clock,
// 32 steps, sign-corrected HI (remainder) / LO (quotient) registered on the last step.
module div_unit (
  input  logic       clock,
  input  logic       reset_n,
  div_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [31:0] rem, quo, dvs, raw_dvd;
  logic [31:0] hi_q, lo_q;
  logic        q_neg, r_neg, dzero;

  logic        start_ok, step_en, finish;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] sub, rem_step, quo_step;
  logic [31:0] dvd_mag, dvs_mag, lo_fix, hi_fix;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    start_ok  = bus.HasDivE && !bus.DivCancel && (state != RUN);
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (count == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = start_ok ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.DivCancel) state_nxt = IDLE;
    step_en = (state == RUN) && !bus.DivCancel;
    finish  = step_en && (count == 5'd31);
  end

  // Magnitudes: 0x80000000 negates to itself, which reads correctly as 2^31 unsigned.
  always_comb begin
    dvd_mag = (bus.DivSignedE && bus.DivDividendE[31]) ? -bus.DivDividendE : bus.DivDividendE;
    dvs_mag = (bus.DivSignedE && bus.DivDivisorE[31])  ? -bus.DivDivisorE  : bus.DivDivisorE;
  end

  // Partial remainder stays below the divisor, so when the subtract succeeds the
  // low 32 bits of the difference are exact.
  always_comb begin
    shifted  = {rem, quo[31]};
    ge       = shifted >= {1'b0, dvs};
    sub      = shifted[31:0] - dvs;
    rem_step = ge ? sub : shifted[31:0];
    quo_step = {quo[30:0], ge};
    lo_fix   = dzero ? '1      : (q_neg ? -quo_step : quo_step);
    hi_fix   = dzero ? raw_dvd : (r_neg ? -rem_step : rem_step);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      raw_dvd <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dzero   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (start_ok) begin
      count   <= '0;
      rem     <= '0;
      quo     <= dvd_mag;
      dvs     <= dvs_mag;
      raw_dvd <= bus.DivDividendE;
      q_neg   <= bus.DivSignedE && (bus.DivDividendE[31] ^ bus.DivDivisorE[31]);
      r_neg   <= bus.DivSignedE && bus.DivDividendE[31];
      dzero   <= (bus.DivDivisorE == '0);
    end else if (step_en) begin
      count <= count + 5'd1;
      rem   <= rem_step;
      quo   <= quo_step;
      if (finish) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
    end
  end

  assign bus.DivBusy = (state == RUN);
  assign bus.HasDivW = (state == DONE);
  assign bus.DivHiW  = hi_q;
  assign bus.DivLoW  = lo_q;
endmodule
